// File: rtl/tt_draw_pkg.sv
// Shared drawing constants and FSM encoding for the rectangle draw arbiter
// and its rasteriser.
package tt_draw_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rect_draw_arbiter_if.sv
// Requester-side bundle plus the pixel-write port towards vga_adapter.
// Per-requester fields are packed side by side, requester i in slice i.
interface rect_draw_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    import tt_draw_pkg::*;

    logic [NUM_REQ-1:0]    req;
    logic [XW*NUM_REQ-1:0] init_x;
    logic [YW*NUM_REQ-1:0] init_y;
    logic [XW*NUM_REQ-1:0] width;
    logic [YW*NUM_REQ-1:0] height;
    logic [CW*NUM_REQ-1:0] color_in;

    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    done;
    logic                  busy;

    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [CW-1:0]         color;
    logic                  plot;

    modport master (
        output req, init_x, init_y, width, height, color_in,
        input  grant, done, busy, x, y, color, plot
    );

    modport slave (
        input  req, init_x, init_y, width, height, color_in,
        output grant, done, busy, x, y, color, plot
    );

endinterface

// File: rtl/rect_raster.sv
// Walks a latched rectangle in row-major order, one pixel per step, and
// reports whether the current pixel is on screen and whether it is the last.
module rect_raster import tt_draw_pkg::*; #(
    parameter int CLIP_W = SCREEN_W,
    parameter int CLIP_H = SCREEN_H
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    input  logic [XW-1:0] base_x,
    input  logic [YW-1:0] base_y,
    input  logic [XW-1:0] width,
    input  logic [YW-1:0] height,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          visible,
    output logic          last_pix
);

    logic [XW-1:0] cx_reg, cx_next;
    logic [YW-1:0] cy_reg, cy_next;
    logic [XW:0]   sx;
    logic [YW:0]   sy;
    logic          col_end;

    // One extra bit on each sum so that coordinates past the screen edge
    // are clipped instead of wrapping back onto the screen.
    assign sx = {1'b0, base_x} + {1'b0, cx_reg};
    assign sy = {1'b0, base_y} + {1'b0, cy_reg};

    assign pix_x    = sx[XW-1:0];
    assign pix_y    = sy[YW-1:0];
    assign visible  = (sx < (XW+1)'(CLIP_W)) && (sy < (YW+1)'(CLIP_H));
    assign col_end  = (cx_reg == width - XW'(1));
    assign last_pix = col_end && (cy_reg == height - YW'(1));

    always_comb begin
        cx_next = cx_reg;
        cy_next = cy_reg;
        if (clear) begin
            cx_next = '0;
            cy_next = '0;
        end else if (step) begin
            if (col_end) begin
                cx_next = '0;
                cy_next = cy_reg + YW'(1);
            end else begin
                cx_next = cx_reg + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_reg <= '0;
            cy_reg <= '0;
        end else begin
            cx_reg <= cx_next;
            cy_reg <= cy_next;
        end
    end

endmodule

// File: rtl/rect_draw_arbiter.sv
// Round-robin owner of the single VGA pixel-write port: latches the winning
// requester's rectangle, rasterises it with clipping and pulses done.
module rect_draw_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SCREEN_W = tt_draw_pkg::SCREEN_W,
    parameter int SCREEN_H = tt_draw_pkg::SCREEN_H
) (
    input  logic             clk,
    input  logic             rst,
    rect_draw_arbiter_if.slave bus
);
    import tt_draw_pkg::*;

    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [XW-1:0] req_x [NUM_REQ];
    logic [YW-1:0] req_y [NUM_REQ];
    logic [XW-1:0] req_w [NUM_REQ];
    logic [YW-1:0] req_h [NUM_REQ];
    logic [CW-1:0] req_c [NUM_REQ];

    state_t             state_reg, state_next;
    logic [LW-1:0]      last_reg, last_next;
    logic [XW-1:0]      lx_reg, lx_next, lw_reg, lw_next;
    logic [YW-1:0]      ly_reg, ly_next, lh_reg, lh_next;
    logic [CW-1:0]      lc_reg, lc_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [NUM_REQ-1:0] done_reg, done_next;
    logic               busy_reg, busy_next;
    logic [XW-1:0]      x_reg, x_next;
    logic [YW-1:0]      y_reg, y_next;
    logic [CW-1:0]      color_reg, color_next;
    logic               plot_reg, plot_next;

    logic               found;
    logic [LW-1:0]      win_idx;
    logic [LW:0]        cand;

    logic [XW-1:0]      pix_x;
    logic [YW-1:0]      pix_y;
    logic               visible;
    logic               last_pix;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_x[gi] = bus.init_x[gi*XW +: XW];
            assign req_y[gi] = bus.init_y[gi*YW +: YW];
            assign req_w[gi] = bus.width[gi*XW +: XW];
            assign req_h[gi] = bus.height[gi*YW +: YW];
            assign req_c[gi] = bus.color_in[gi*CW +: CW];
        end
    endgenerate

    // Search starts just after the previous winner, so a requester that
    // keeps req high is queued behind everyone else.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_reg} + (LW+1)'(k);
            if (cand >= (LW+1)'(NUM_REQ)) begin
                cand = cand - (LW+1)'(NUM_REQ);
            end
            if (!found && bus.req[cand[LW-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[LW-1:0];
            end
        end
    end

    rect_raster #(
        .CLIP_W (SCREEN_W),
        .CLIP_H (SCREEN_H)
    ) u_raster (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_reg == ST_IDLE),
        .step     (state_reg == ST_DRAW),
        .base_x   (lx_reg),
        .base_y   (ly_reg),
        .width    (lw_reg),
        .height   (lh_reg),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .visible  (visible),
        .last_pix (last_pix)
    );

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        lx_next    = lx_reg;
        ly_next    = ly_reg;
        lw_next    = lw_reg;
        lh_next    = lh_reg;
        lc_next    = lc_reg;
        grant_next = grant_reg;
        done_next  = '0;
        busy_next  = busy_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        color_next = color_reg;
        plot_next  = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (found) begin
                    lx_next    = req_x[win_idx];
                    ly_next    = req_y[win_idx];
                    lw_next    = req_w[win_idx];
                    lh_next    = req_h[win_idx];
                    lc_next    = req_c[win_idx];
                    grant_next = NUM_REQ'(1) << win_idx;
                    busy_next  = 1'b1;
                    last_next  = win_idx;
                    // An empty rectangle skips straight to the done pulse.
                    if (req_w[win_idx] == '0 || req_h[win_idx] == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_DRAW;
                    end
                end
            end
            ST_DRAW: begin
                if (visible) begin
                    x_next     = pix_x;
                    y_next     = pix_y;
                    color_next = lc_reg;
                    plot_next  = 1'b1;
                end
                if (last_pix) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_next  = grant_reg;
                grant_next = '0;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            last_reg  <= LW'(NUM_REQ - 1);
            lx_reg    <= '0;
            ly_reg    <= '0;
            lw_reg    <= '0;
            lh_reg    <= '0;
            lc_reg    <= '0;
            grant_reg <= '0;
            done_reg  <= '0;
            busy_reg  <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            color_reg <= '0;
            plot_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            lx_reg    <= lx_next;
            ly_reg    <= ly_next;
            lw_reg    <= lw_next;
            lh_reg    <= lh_next;
            lc_reg    <= lc_next;
            grant_reg <= grant_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            color_reg <= color_next;
            plot_reg  <= plot_next;
        end
    end

    assign bus.grant = grant_reg;
    assign bus.done  = done_reg;
    assign bus.busy  = busy_reg;
    assign bus.x     = x_reg;
    assign bus.y     = y_reg;
    assign bus.color = color_reg;
    assign bus.plot  = plot_reg;

endmodule

// File: tb/tb_rect_draw_arbiter.sv
// Scoreboard bench for rect_draw_arbiter: a pixel model fills a queue per job
// and each DRAW cycle pops one entry and compares the pixel port against it.
module tb_rect_draw_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic       vis;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    pix_t exp_q[$];
    logic [8:0] hold_x;
    logic [7:0] hold_y;
    logic [2:0] hold_c;

    rect_draw_arbiter_if #(.NUM_REQ(N)) bus ();

    rect_draw_arbiter #(.NUM_REQ(N), .SCREEN_W(320), .SCREEN_H(240)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_rect(input int i, input int x0, input int y0, input int w, input int h,
                            input logic [2:0] c);
        bus.init_x[i*9 +: 9]   = 9'(x0);
        bus.init_y[i*8 +: 8]   = 8'(y0);
        bus.width[i*9 +: 9]    = 9'(w);
        bus.height[i*8 +: 8]   = 8'(h);
        bus.color_in[i*3 +: 3] = c;
    endtask

    // Reference rasteriser: one entry per DRAW cycle, row-major, clipped.
    task automatic push_rect(input int x0, input int y0, input int w, input int h,
                             input logic [2:0] c);
        pix_t p;
        int   sx;
        int   sy;
        for (int j = 0; j < h; j++) begin
            for (int i = 0; i < w; i++) begin
                sx    = x0 + i;
                sy    = y0 + j;
                p.vis = (sx < 320) && (sy < 240);
                p.x   = 9'(sx);
                p.y   = 8'(sy);
                p.c   = c;
                exp_q.push_back(p);
            end
        end
    endtask

    // Called at the negedge where req was applied; returns at the negedge
    // where done is expected to be high.
    task automatic observe_job(input logic [3:0] g, input int n, input string tag);
        pix_t p;
        int   plots;
        plots = 0;
        @(negedge clk);
        vectors++;
        if (bus.grant !== g || bus.busy !== 1'b1 || bus.plot !== 1'b0) begin
            miscompares++;
            $display("FAIL %s accept: grant=%b busy=%b plot=%b, want grant=%b busy=1 plot=0",
                     tag, bus.grant, bus.busy, bus.plot, g);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s pixel %0d: scoreboard empty, plot=%b", tag, k, bus.plot);
            end else begin
                p = exp_q.pop_front();
                if (p.vis) begin
                    hold_x = p.x;
                    hold_y = p.y;
                    hold_c = p.c;
                    plots++;
                end
                if (bus.plot !== p.vis || bus.x !== hold_x || bus.y !== hold_y ||
                    bus.color !== hold_c || bus.grant !== g) begin
                    miscompares++;
                    $display("FAIL %s pixel %0d: plot=%b x=%0d y=%0d c=%b g=%b, want plot=%b x=%0d y=%0d c=%b g=%b",
                             tag, k, bus.plot, bus.x, bus.y, bus.color, bus.grant,
                             p.vis, hold_x, hold_y, hold_c, g);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== g || bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.plot !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done: done=%b grant=%b busy=%b plot=%b, want done=%b grant=0 busy=0 plot=0",
                     tag, bus.done, bus.grant, bus.busy, bus.plot, g);
        end
        $display("job %s: grant=%b draw_cycles=%0d plots=%0d", tag, g, n, plots);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.init_x = '0;
        bus.init_y = '0;
        bus.width = '0;
        bus.height = '0;
        bus.color_in = '0;
        hold_x = '0;
        hold_y = '0;
        hold_c = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0 || bus.done !== 4'b0 || bus.busy !== 1'b0 || bus.x !== 9'd0 ||
            bus.y !== 8'd0 || bus.color !== 3'd0 || bus.plot !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: grant=%b done=%b busy=%b x=%0d y=%0d c=%b plot=%b, want all 0",
                     bus.grant, bus.done, bus.busy, bus.x, bus.y, bus.color, bus.plot);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_rect();
        set_rect(0, 10, 20, 2, 2, 3'b001);
        push_rect(10, 20, 2, 2, 3'b001);
        bus.req = 4'b0001;
        observe_job(4'b0001, 4, "single");
        bus.req = 4'b0000;
        @(negedge clk);
        vectors++;
        if (bus.done !== 4'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single after: done=%b busy=%b, want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_arbitration();
        test_reset();
        set_rect(0, 1, 1, 1, 1, 3'b010);
        set_rect(2, 7, 9, 2, 1, 3'b100);
        push_rect(1, 1, 1, 1, 3'b010);
        bus.req = 4'b0101;
        observe_job(4'b0001, 1, "arb0");
        bus.req = 4'b0100;
        push_rect(7, 9, 2, 1, 3'b100);
        observe_job(4'b0100, 2, "arb2");
        // Both held: ownership must alternate.
        bus.req = 4'b0101;
        for (int r = 0; r < 2; r++) begin
            push_rect(1, 1, 1, 1, 3'b010);
            observe_job(4'b0001, 1, "hold0");
            push_rect(7, 9, 2, 1, 3'b100);
            observe_job(4'b0100, 2, "hold2");
        end
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_degenerate();
        set_rect(1, 30, 30, 0, 5, 3'b111);
        bus.req = 4'b0010;
        observe_job(4'b0010, 0, "zero_w");
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_clipping();
        set_rect(2, 318, 5, 4, 1, 3'b110);
        push_rect(318, 5, 4, 1, 3'b110);
        bus.req = 4'b0100;
        observe_job(4'b0100, 4, "clip_x");
        bus.req = 4'b0000;
        @(negedge clk);
        set_rect(3, 100, 238, 1, 3, 3'b011);
        push_rect(100, 238, 1, 3, 3'b011);
        bus.req = 4'b1000;
        observe_job(4'b1000, 3, "clip_y");
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_draw();
        set_rect(0, 40, 40, 10, 10, 3'b101);
        bus.req = 4'b0001;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.grant !== 4'b0 || bus.done !== 4'b0 || bus.busy !== 1'b0 || bus.x !== 9'd0 ||
            bus.y !== 8'd0 || bus.color !== 3'd0 || bus.plot !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: grant=%b done=%b busy=%b x=%0d y=%0d c=%b plot=%b, want all 0",
                     bus.grant, bus.done, bus.busy, bus.x, bus.y, bus.color, bus.plot);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.plot !== 1'b0 || bus.done !== 4'b0) begin
            miscompares++;
            $display("FAIL mid_reset hold: busy=%b plot=%b done=%b, want 0", bus.busy, bus.plot, bus.done);
        end
        hold_x = '0;
        hold_y = '0;
        hold_c = '0;
        set_rect(0, 5, 6, 1, 1, 3'b001);
        set_rect(3, 8, 9, 1, 1, 3'b010);
        push_rect(5, 6, 1, 1, 3'b001);
        rst = 1'b0;
        bus.req = 4'b1001;
        observe_job(4'b0001, 1, "post_reset0");
        bus.req = 4'b1000;
        push_rect(8, 9, 1, 1, 3'b010);
        observe_job(4'b1000, 1, "post_reset3");
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_withdrawn();
        set_rect(0, 50, 60, 3, 2, 3'b101);
        push_rect(50, 60, 3, 2, 3'b101);
        bus.req = 4'b0001;
        fork
            observe_job(4'b0001, 6, "withdrawn");
            begin
                repeat (2) @(negedge clk);
                bus.req = 4'b0000;
                set_rect(0, 200, 100, 1, 1, 3'b010);
            end
        join
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL withdrawn idle: grant=%b busy=%b, want 0 0", bus.grant, bus.busy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_rect();
        test_arbitration();
        test_degenerate();
        test_clipping();
        test_reset_mid_draw();
        test_withdrawn();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
